// File: rtl/iagc_pkg.sv
// Shared state codes, opcodes and helpers for the IAGC control FSM.
package iagc_pkg;

  localparam int unsigned STATUS_W = 4;

  typedef enum logic [STATUS_W-1:0] {
    ST_RESET     = 4'd0,
    ST_INIT      = 4'd1,
    ST_IDLE      = 4'd2,
    ST_SAMPLE    = 4'd3,
    ST_CMD_PARSE = 4'd4,
    ST_CMD_READ  = 4'd5,
    ST_CMD_ERROR = 4'd6,
    ST_DUMP_REF  = 4'd7,
    ST_DUMP_ERR  = 4'd8,
    ST_CLEAN_MEM = 4'd9,
    ST_SET_MEM   = 4'd10,
    ST_SET_DEC   = 4'd11,
    ST_HALT      = 4'd12,
    ST_TIMEOUT   = 4'd13
  } state_e;

  localparam int unsigned OP_EMPTY     = 0;
  localparam int unsigned OP_RESET     = 1;
  localparam int unsigned OP_SAMPLE    = 2;
  localparam int unsigned OP_SET_DEC   = 3;
  localparam int unsigned OP_CLEAN_MEM = 4;
  localparam int unsigned OP_DUMP_REF  = 5;
  localparam int unsigned OP_DUMP_ERR  = 6;
  localparam int unsigned OP_SET_MEM   = 7;
  localparam int unsigned OP_HALT      = 8;

  // States that run a datapath and are guarded by the watchdog.
  function automatic logic is_long(input state_e s);
    return (s == ST_SAMPLE) || (s == ST_DUMP_REF) ||
           (s == ST_DUMP_ERR) || (s == ST_CLEAN_MEM);
  endfunction

endpackage

// File: rtl/iagc_watchdog.sv
// Cycle counter for long operations: clears, counts while enabled, flags the last allowed cycle.
module iagc_watchdog #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LIMIT = 50000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire_c
);

  logic [WIDTH-1:0] r_count;

  // Count cycles spent in the guarded operation.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_expire_c = i_enable && (r_count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/iagc_ctrl_fsm.sv
// Top-level IAGC control FSM: init, sampling, host command decode/validation, watchdog.
module iagc_ctrl_fsm
  import iagc_pkg::*;
#(
  parameter int unsigned STATUS_SIZE    = 4,
  parameter int unsigned CMD_PARAM_SIZE = 4,
  parameter int unsigned ADDR_SIZE      = 12,
  parameter int unsigned DECIMATOR_SIZE = 4,
  parameter int unsigned DEF_DECIMATOR  = 4,
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned CH_SEL_SIZE    = 1,
  parameter int unsigned TIMEOUT_SIZE   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_adc_init_done,
  input  logic                      i_dac_init_done,
  input  logic                      i_sample,
  input  logic                      i_cmd_valid,
  input  logic [CMD_PARAM_SIZE-1:0] i_cmd_operation,
  input  logic [CMD_PARAM_SIZE-1:0] i_cmd_parameter,
  input  logic [CH_SEL_SIZE-1:0]    i_cmd_channel,
  input  logic                      i_sample_end,
  input  logic                      i_dump_end,
  input  logic                      i_clean_end,
  output logic [ADDR_SIZE:0]        o_memory_size,
  output logic [DECIMATOR_SIZE-1:0] o_decimator,
  output logic [CH_SEL_SIZE-1:0]    o_channel,
  output logic [STATUS_SIZE-1:0]    o_status,
  output logic                      o_cmd_ack,
  output logic                      o_cmd_err,
  output logic                      o_timeout,
  output logic                      o_busy
);

  localparam int unsigned MEM_W = ADDR_SIZE + 1;

  state_e                      r_state;
  state_e                      w_next_state;
  logic [CMD_PARAM_SIZE-1:0]   r_cmd_op;
  logic [CMD_PARAM_SIZE-1:0]   r_cmd_param;
  logic [CH_SEL_SIZE-1:0]      r_cmd_ch;
  logic [MEM_W-1:0]            r_mem_size;
  logic [DECIMATOR_SIZE-1:0]   r_decimator;
  logic [CH_SEL_SIZE-1:0]      r_channel;
  logic                        r_ack;
  logic                        r_err;
  logic                        r_busy;
  logic                        r_timeout;

  logic w_latch_cmd;
  logic w_ack;
  logic w_err;
  logic w_busy;
  logic w_ld_channel;
  logic w_set_mem;
  logic w_set_dec;
  logic w_soft_rst;
  logic w_ch_ok;
  logic w_wd_active;
  logic w_wd_expire;

  assign w_ch_ok     = 32'(r_cmd_ch) < NUM_CH;
  assign w_wd_active = is_long(r_state);

  iagc_watchdog #(
    .WIDTH (TIMEOUT_SIZE),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    (!w_wd_active),
    .i_enable   (w_wd_active),
    .o_expire_c (w_wd_expire)
  );

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and per-transition strobes.
  always_comb begin
    w_next_state = r_state;
    w_latch_cmd  = 1'b0;
    w_ack        = 1'b0;
    w_ld_channel = 1'b0;
    w_set_mem    = 1'b0;
    w_set_dec    = 1'b0;
    w_soft_rst   = 1'b0;
    case (r_state)
      ST_RESET: w_next_state = ST_INIT;
      ST_INIT: begin
        if (i_adc_init_done && i_dac_init_done) w_next_state = ST_IDLE;
      end
      ST_IDLE: begin
        // Fields are captured together with the valid strobe so single-cycle commands work.
        if (i_cmd_valid) begin
          w_next_state = ST_CMD_PARSE;
          w_latch_cmd  = 1'b1;
        end else if (i_sample) begin
          w_next_state = ST_SAMPLE;
        end
      end
      ST_CMD_PARSE: w_next_state = ST_CMD_READ;
      ST_CMD_READ: begin
        case (32'(r_cmd_op))
          OP_EMPTY:     w_next_state = ST_IDLE;
          OP_RESET: begin
            w_next_state = ST_RESET;
            w_soft_rst   = 1'b1;
          end
          OP_SAMPLE:    w_next_state = w_ch_ok ? ST_SAMPLE    : ST_CMD_ERROR;
          OP_SET_DEC:   w_next_state = (r_cmd_param != '0) ? ST_SET_DEC : ST_CMD_ERROR;
          OP_CLEAN_MEM: w_next_state = w_ch_ok ? ST_CLEAN_MEM : ST_CMD_ERROR;
          OP_DUMP_REF:  w_next_state = w_ch_ok ? ST_DUMP_REF  : ST_CMD_ERROR;
          OP_DUMP_ERR:  w_next_state = w_ch_ok ? ST_DUMP_ERR  : ST_CMD_ERROR;
          OP_SET_MEM:   w_next_state = (32'(r_cmd_param) > ADDR_SIZE) ? ST_CMD_ERROR : ST_SET_MEM;
          OP_HALT:      w_next_state = ST_HALT;
          default:      w_next_state = ST_CMD_ERROR;
        endcase
        w_ack        = (w_next_state != ST_IDLE) && (w_next_state != ST_CMD_ERROR);
        w_ld_channel = is_long(w_next_state);
      end
      ST_CMD_ERROR: w_next_state = ST_IDLE;
      ST_SAMPLE: begin
        if (i_sample_end)     w_next_state = ST_IDLE;
        else if (w_wd_expire) w_next_state = ST_TIMEOUT;
      end
      ST_DUMP_REF, ST_DUMP_ERR: begin
        if (i_dump_end)       w_next_state = ST_IDLE;
        else if (w_wd_expire) w_next_state = ST_TIMEOUT;
      end
      ST_CLEAN_MEM: begin
        if (i_clean_end)      w_next_state = ST_IDLE;
        else if (w_wd_expire) w_next_state = ST_TIMEOUT;
      end
      ST_SET_MEM: begin
        w_next_state = ST_IDLE;
        w_set_mem    = 1'b1;
      end
      ST_SET_DEC: begin
        w_next_state = ST_IDLE;
        w_set_dec    = 1'b1;
      end
      ST_HALT:    w_next_state = ST_HALT;
      ST_TIMEOUT: w_next_state = ST_IDLE;
      default:    w_next_state = ST_RESET;
    endcase
  end

  assign w_err  = (w_next_state == ST_CMD_ERROR);
  assign w_busy = is_long(w_next_state);

  // Latched command fields.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cmd_op    <= '0;
      r_cmd_param <= '0;
      r_cmd_ch    <= '0;
    end else if (w_latch_cmd) begin
      r_cmd_op    <= i_cmd_operation;
      r_cmd_param <= i_cmd_parameter;
      r_cmd_ch    <= i_cmd_channel;
    end
  end

  // Configuration registers; soft reset restores defaults.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_mem_size  <= MEM_W'(1) << ADDR_SIZE;
      r_decimator <= DECIMATOR_SIZE'(DEF_DECIMATOR);
      r_channel   <= '0;
    end else begin
      if (w_soft_rst) begin
        r_mem_size  <= MEM_W'(1) << ADDR_SIZE;
        r_decimator <= DECIMATOR_SIZE'(DEF_DECIMATOR);
      end else begin
        if (w_set_mem) r_mem_size  <= MEM_W'(1) << r_cmd_param;
        if (w_set_dec) r_decimator <= DECIMATOR_SIZE'(r_cmd_param);
      end
      if (w_ld_channel) r_channel <= r_cmd_ch;
    end
  end

  // Handshake pulses, busy and sticky timeout flag, aligned with the state they describe.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_ack  <= w_ack;
      r_err  <= w_err;
      r_busy <= w_busy;
      if (w_ack) begin
        r_timeout <= 1'b0;
      end else if (w_next_state == ST_TIMEOUT) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_memory_size = r_mem_size;
  assign o_decimator   = r_decimator;
  assign o_channel     = r_channel;
  assign o_status      = STATUS_SIZE'(r_state);
  assign o_cmd_ack     = r_ack;
  assign o_cmd_err     = r_err;
  assign o_timeout     = r_timeout;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_iagc_ctrl_fsm.sv
// Self-checking bench for iagc_ctrl_fsm with a command-level reference model.
module tb_iagc_ctrl_fsm;

  localparam int TO     = 24;
  localparam int NUM_CH = 2;

  logic        clk;
  logic        i_reset;
  logic        i_adc_init_done, i_dac_init_done, i_sample, i_cmd_valid;
  logic [3:0]  i_cmd_operation, i_cmd_parameter;
  logic [1:0]  i_cmd_channel;
  logic        i_sample_end, i_dump_end, i_clean_end;
  logic [12:0] o_memory_size;
  logic [3:0]  o_decimator;
  logic [1:0]  o_channel;
  logic [3:0]  o_status;
  logic        o_cmd_ack, o_cmd_err, o_timeout, o_busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the configuration visible to the host.
  int m_mem;
  int m_dec;
  int m_ch;
  bit m_to;

  iagc_ctrl_fsm #(
    .NUM_CH         (NUM_CH),
    .CH_SEL_SIZE    (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clock         (clk),
    .i_reset         (i_reset),
    .i_adc_init_done (i_adc_init_done),
    .i_dac_init_done (i_dac_init_done),
    .i_sample        (i_sample),
    .i_cmd_valid     (i_cmd_valid),
    .i_cmd_operation (i_cmd_operation),
    .i_cmd_parameter (i_cmd_parameter),
    .i_cmd_channel   (i_cmd_channel),
    .i_sample_end    (i_sample_end),
    .i_dump_end      (i_dump_end),
    .i_clean_end     (i_clean_end),
    .o_memory_size   (o_memory_size),
    .o_decimator     (o_decimator),
    .o_channel       (o_channel),
    .o_status        (o_status),
    .o_cmd_ack       (o_cmd_ack),
    .o_cmd_err       (o_cmd_err),
    .o_timeout       (o_timeout),
    .o_busy          (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Where a command should land, from the opcode/validation rules.
  function automatic int exp_target(input int op, input int param, input int ch);
    bit ch_ok;
    ch_ok = (ch < NUM_CH);
    case (op)
      0: return 2;
      1: return 0;
      2: return ch_ok ? 3 : 6;
      3: return (param != 0) ? 11 : 6;
      4: return ch_ok ? 9 : 6;
      5: return ch_ok ? 7 : 6;
      6: return ch_ok ? 8 : 6;
      7: return (param <= 12) ? 10 : 6;
      8: return 12;
      default: return 6;
    endcase
  endfunction

  // Drive the finish strobe for op (hit) plus random noise on the unrelated strobes.
  task automatic set_ends(input int op, input bit hit);
    bit [2:0] noise;
    noise = 3'($urandom);
    i_sample_end = (op == 2) ? hit : noise[0];
    i_clean_end  = (op == 4) ? hit : noise[1];
    i_dump_end   = (op == 5 || op == 6) ? hit : noise[2];
  endtask

  task automatic clear_ends();
    i_sample_end = 1'b0;
    i_clean_end  = 1'b0;
    i_dump_end   = 1'b0;
  endtask

  task automatic reset_model();
    m_mem = 4096;
    m_dec = 4;
    m_ch  = 0;
    m_to  = 1'b0;
  endtask

  // Issue one command from IDLE and follow it until it is back in IDLE (or halted).
  task automatic do_cmd(input int op, input int param, input int ch, input int dur, input bit with_sample);
    int tgt;
    bit exp_ack, exp_err;
    tgt     = exp_target(op, param, ch);
    exp_ack = !(tgt == 2 || tgt == 6);
    exp_err = (tgt == 6);
    n_checks++;
    if (o_status !== 4'd2) begin
      n_errors++; $display("FAIL cmd_pre_idle op=%0d got=%0d want=2", op, o_status);
    end
    i_cmd_valid = 1'b1; i_sample = with_sample;
    i_cmd_operation = 4'(op); i_cmd_parameter = 4'(param); i_cmd_channel = 2'(ch);
    tick();
    i_cmd_valid = 1'b0; i_sample = 1'b0;
    n_checks++;
    if (o_status !== 4'd4) begin
      n_errors++; $display("FAIL cmd_parse op=%0d got=%0d want=4", op, o_status);
    end
    tick();
    i_cmd_operation = 4'($urandom); i_cmd_parameter = 4'($urandom); i_cmd_channel = 2'($urandom);
    n_checks++;
    if (o_status !== 4'd5) begin
      n_errors++; $display("FAIL cmd_read op=%0d got=%0d want=5", op, o_status);
    end
    tick();
    if (exp_ack) m_to = 1'b0;
    if (tgt == 3 || tgt == 7 || tgt == 8 || tgt == 9) m_ch = ch;
    if (tgt == 0) begin m_mem = 4096; m_dec = 4; end
    n_checks++;
    if ({o_status, o_cmd_ack, o_cmd_err} !== {4'(tgt), exp_ack, exp_err}) begin
      n_errors++; $display("FAIL cmd_decode op=%0d p=%0d ch=%0d got={st=%0d ack=%b err=%b} want={st=%0d ack=%b err=%b}",
                           op, param, ch, o_status, o_cmd_ack, o_cmd_err, tgt, exp_ack, exp_err);
    end
    n_checks++;
    if ({o_channel, o_timeout} !== {2'(m_ch), m_to}) begin
      n_errors++; $display("FAIL cmd_flags op=%0d got={ch=%0d to=%b} want={ch=%0d to=%b}", op, o_channel, o_timeout, m_ch, m_to);
    end
    case (tgt)
      3, 7, 8, 9: begin
        for (int k = 1; k <= ((dur <= TO) ? dur : TO); k++) begin
          n_checks++;
          if ({o_status, o_busy} !== {4'(tgt), 1'b1}) begin
            n_errors++; $display("FAIL long_run op=%0d k=%0d got={st=%0d busy=%b} want={st=%0d busy=1}", op, k, o_status, o_busy, tgt);
          end
          set_ends(op, (k == dur));
          tick();
          clear_ends();
        end
        if (dur <= TO) begin
          n_checks++;
          if ({o_status, o_busy, o_cmd_ack} !== {4'd2, 1'b0, 1'b0}) begin
            n_errors++; $display("FAIL long_end op=%0d dur=%0d got={st=%0d busy=%b ack=%b} want={st=2 busy=0 ack=0}", op, dur, o_status, o_busy, o_cmd_ack);
          end
        end else begin
          m_to = 1'b1;
          n_checks++;
          if ({o_status, o_busy, o_timeout} !== {4'd13, 1'b0, 1'b1}) begin
            n_errors++; $display("FAIL long_timeout op=%0d got={st=%0d busy=%b to=%b} want={st=13 busy=0 to=1}", op, o_status, o_busy, o_timeout);
          end
          tick();
          n_checks++;
          if ({o_status, o_timeout} !== {4'd2, 1'b1}) begin
            n_errors++; $display("FAIL timeout_exit got={st=%0d to=%b} want={st=2 to=1}", o_status, o_timeout);
          end
        end
      end
      10, 11, 6: begin
        if (tgt == 10) m_mem = 1 << param;
        if (tgt == 11) m_dec = param;
        tick();
        n_checks++;
        if ({o_status, o_cmd_ack, o_cmd_err} !== {4'd2, 1'b0, 1'b0}) begin
          n_errors++; $display("FAIL cmd_return op=%0d got={st=%0d ack=%b err=%b} want={st=2 ack=0 err=0}", op, o_status, o_cmd_ack, o_cmd_err);
        end
      end
      0: begin
        tick();
        n_checks++;
        if (o_status !== 4'd1) begin
          n_errors++; $display("FAIL soft_reset_init got=%0d want=1", o_status);
        end
        tick();
        n_checks++;
        if (o_status !== 4'd2) begin
          n_errors++; $display("FAIL soft_reset_idle got=%0d want=2", o_status);
        end
      end
      default: ;
    endcase
    n_checks++;
    if ({o_memory_size, o_decimator} !== {13'(m_mem), 4'(m_dec)}) begin
      n_errors++; $display("FAIL cmd_config op=%0d got={mem=%0d dec=%0d} want={mem=%0d dec=%0d}", op, o_memory_size, o_decimator, m_mem, m_dec);
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if ({o_status, o_memory_size, o_decimator, o_channel, o_cmd_ack, o_cmd_err, o_timeout, o_busy} !==
        {4'd0, 13'd4096, 4'd4, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_errors++; $display("FAIL %s got={st=%0d mem=%0d dec=%0d ch=%0d ack=%b err=%b to=%b busy=%b} want={0 4096 4 0 0 0 0 0}",
                           tag, o_status, o_memory_size, o_decimator, o_channel, o_cmd_ack, o_cmd_err, o_timeout, o_busy);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_adc_init_done = 1'b0; i_dac_init_done = 1'b0; i_sample = 1'b0; i_cmd_valid = 1'b0;
    i_cmd_operation = '0; i_cmd_parameter = '0; i_cmd_channel = '0;
    clear_ends();
    reset_model();
    repeat (2) tick();
    check_reset_values("reset_values");
  endtask

  task automatic test_init();
    i_adc_init_done = 1'b1; i_dac_init_done = 1'b0;
    i_reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (o_status !== 4'd1) begin
        n_errors++; $display("FAIL init_hold cyc=%0d got=%0d want=1", i, o_status);
      end
    end
    i_dac_init_done = 1'b1;
    tick();
    n_checks++;
    if ({o_status, o_memory_size, o_decimator} !== {4'd2, 13'd4096, 4'd4}) begin
      n_errors++; $display("FAIL init_done got={st=%0d mem=%0d dec=%0d} want={2 4096 4}", o_status, o_memory_size, o_decimator);
    end
  endtask

  task automatic test_set_mem();
    do_cmd(7, 10, 0, 0, 1'b0);
    do_cmd(7, 13, 0, 0, 1'b0);
    do_cmd(7, 12, 0, 0, 1'b0);
    do_cmd(7, 0, 0, 0, 1'b0);
  endtask

  task automatic test_dump();
    do_cmd(5, 0, 1, 20, 1'b0);
    do_cmd(5, 0, 2, 0, 1'b0);
    do_cmd(6, 3, 0, 5, 1'b0);
    do_cmd(2, 0, 3, 0, 1'b0);
  endtask

  task automatic test_timeout();
    do_cmd(4, 0, 0, TO + 5, 1'b0);
    do_cmd(7, 14, 0, 0, 1'b0);
    do_cmd(0, 0, 0, 0, 1'b0);
    do_cmd(3, 5, 0, 0, 1'b0);
    do_cmd(2, 0, 1, TO, 1'b0);
  endtask

  task automatic test_sample_idle();
    i_sample = 1'b1;
    tick();
    i_sample = 1'b0;
    n_checks++;
    if ({o_status, o_busy, o_cmd_ack, o_channel} !== {4'd3, 1'b1, 1'b0, 2'(m_ch)}) begin
      n_errors++; $display("FAIL idle_sample got={st=%0d busy=%b ack=%b ch=%0d} want={3 1 0 %0d}", o_status, o_busy, o_cmd_ack, o_channel, m_ch);
    end
    repeat (2) tick();
    set_ends(2, 1'b1);
    tick();
    clear_ends();
    n_checks++;
    if ({o_status, o_busy} !== {4'd2, 1'b0}) begin
      n_errors++; $display("FAIL idle_sample_end got={st=%0d busy=%b} want={2 0}", o_status, o_busy);
    end
  endtask

  task automatic test_priority();
    do_cmd(3, 0, 0, 0, 1'b1);
    do_cmd(1, 0, 0, 0, 1'b1);
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 15));
      if (op == 8) op = 0;
      do_cmd(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), int'($urandom_range(1, TO + 3)), 1'($urandom));
    end
  endtask

  task automatic test_halt();
    do_cmd(8, 0, 0, 0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      i_cmd_valid = 1'($urandom); i_sample = 1'($urandom);
      i_cmd_operation = 4'($urandom); i_cmd_parameter = 4'($urandom);
      tick();
      n_checks++;
      if ({o_status, o_busy} !== {4'd12, 1'b0}) begin
        n_errors++; $display("FAIL halt_hold cyc=%0d got={st=%0d busy=%b} want={12 0}", i, o_status, o_busy);
      end
    end
    i_cmd_valid = 1'b0; i_sample = 1'b0;
    i_reset = 1'b1;
    #1;
    reset_model();
    check_reset_values("halt_reset");
  endtask

  task automatic test_async_reset();
    tick();
    i_reset = 1'b0;
    tick();
    tick();
    do_cmd(7, 5, 0, 0, 1'b0);
    do_cmd(3, 9, 0, 0, 1'b0);
    i_cmd_valid = 1'b1; i_cmd_operation = 4'd5; i_cmd_channel = 2'd1;
    tick();
    i_cmd_valid = 1'b0;
    repeat (5) tick();
    n_checks++;
    if ({o_status, o_busy, o_channel} !== {4'd7, 1'b1, 2'd1}) begin
      n_errors++; $display("FAIL mid_dump got={st=%0d busy=%b ch=%0d} want={7 1 1}", o_status, o_busy, o_channel);
    end
    #2;
    i_reset = 1'b1;
    #1;
    reset_model();
    check_reset_values("async_reset");
    tick();
    i_reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init();
    test_set_mem();
    test_dump();
    test_timeout();
    test_sample_idle();
    test_priority();
    test_random();
    test_halt();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
